multicycle_control_fsm: RTL

//  Multi-cycle RV32I control unit, successor to the single-cycle decoder. Sequences

---
 rtl/riscv_mc_pkg.sv | 51 +++++
 rtl/mc_alu_decoder.sv | 30 +++
 rtl/multicycle_control_fsm.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/riscv_mc_pkg.sv
// Shared opcodes, FSM state encoding and ALU codes for the multi-cycle RV32I control unit.
package riscv_mc_pkg;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_MEMADR,
        S_MEMREAD,
        S_MEMWB,
        S_MEMWRITE,
        S_EXEC_R,
        S_EXEC_I,
        S_ALUWB,
        S_JAL,
        S_BRANCH,
        S_TRAP
    } state_t;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;

    typedef enum logic [1:0] {
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } alu_op_t;

    // Immediate format follows the opcode alone, independent of the FSM state.
    function automatic logic [1:0] imm_src_of(input logic [6:0] op);
        logic [1:0] imm;
        imm = 2'b00;
        case (op)
            OP_STORE:  imm = 2'b01;
            OP_BRANCH: imm = 2'b10;
            OP_JAL:    imm = 2'b11;
            default:   imm = 2'b00;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/mc_alu_decoder.sv
// Combinational ALU control decode from the FSM's alu_op plus funct3/funct7b5/opcode[5].
module mc_alu_decoder
    import riscv_mc_pkg::*;
(
    input  alu_op_t    alu_op,
    input  logic [2:0] funct3,
    input  logic       funct7b5,
    input  logic       op5,
    output logic [2:0] alu_control
);

    always_comb begin
        alu_control = ALU_ADD;
        case (alu_op)
            ALUOP_SUB: alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // op5 separates R-type from I-type so addi never becomes a subtract
                    3'b000:  alu_control = (op5 && funct7b5) ? ALU_SUB : ALU_ADD;
                    3'b010:  alu_control = ALU_SLT;
                    3'b110:  alu_control = ALU_OR;
                    3'b111:  alu_control = ALU_AND;
                    default: alu_control = ALU_ADD;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control FSM with memory stalls, timeout and illegal-opcode trap.
// Optional macro BRANCH_EXT_EN adds bge/bltu/bgeu branch conditions.
module multicycle_control_fsm
    import riscv_mc_pkg::*;
#(
    parameter int ALU_CTRL_W  = 3,
    parameter int MEM_TIMEOUT = 15,
    parameter int TO_W        = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [6:0]            opcode,
    input  logic [2:0]            funct3,
    input  logic                  funct7b5,
    input  logic                  zero,
    input  logic                  lt,
    input  logic                  ltu,
    input  logic                  mem_ready,
    output logic                  pc_write,
    output logic                  adr_src,
    output logic                  mem_write,
    output logic                  mem_req,
    output logic                  ir_write,
    output logic [1:0]            result_src,
    output logic [1:0]            alu_src_a,
    output logic [1:0]            alu_src_b,
    output logic [1:0]            imm_src,
    output logic                  reg_write,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  illegal_instr,
    output logic                  bus_err
);

    localparam logic [TO_W:0]   LIMIT   = (TO_W+1)'(MEM_TIMEOUT);
    localparam logic [TO_W-1:0] CNT_ONE = {{(TO_W-1){1'b0}}, 1'b1};

    state_t          state_reg;
    state_t          wait_exit;
    logic            in_wait;
    logic [TO_W-1:0] to_cnt_reg;
    logic            timeout_hit;
    logic            illegal_reg;
    logic            bus_err_reg;
    logic            take;
    alu_op_t         alu_op;
    logic [2:0]      alu_ctrl3;
    logic            pc_write_c, mem_write_c, mem_req_c, ir_write_c, reg_write_c;

    always_comb begin
        in_wait   = 1'b1;
        wait_exit = S_FETCH;
        case (state_reg)
            S_FETCH:    wait_exit = S_DECODE;
            S_MEMREAD:  wait_exit = S_MEMWB;
            S_MEMWRITE: wait_exit = S_FETCH;
            default:    in_wait   = 1'b0;
        endcase
    end

    // The limit is judged on the stall being counted now, so a ready in that same cycle wins.
    assign timeout_hit = (MEM_TIMEOUT != 0) &&
                         (({1'b0, to_cnt_reg} + {{TO_W{1'b0}}, 1'b1}) == LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg   <= S_FETCH;
            to_cnt_reg  <= '0;
            illegal_reg <= 1'b0;
            bus_err_reg <= 1'b0;
        end else begin
            to_cnt_reg <= '0;
            if (in_wait) begin
                if (mem_ready) begin
                    state_reg <= wait_exit;
                end else if (timeout_hit) begin
                    state_reg   <= S_TRAP;
                    bus_err_reg <= 1'b1;
                end else if (MEM_TIMEOUT != 0) begin
                    to_cnt_reg <= to_cnt_reg + CNT_ONE;
                end
            end else begin
                case (state_reg)
                    S_DECODE: begin
                        case (opcode)
                            OP_LOAD, OP_STORE: state_reg <= S_MEMADR;
                            OP_RTYPE:          state_reg <= S_EXEC_R;
                            OP_ITYPE:          state_reg <= S_EXEC_I;
                            OP_BRANCH:         state_reg <= S_BRANCH;
                            OP_JAL:            state_reg <= S_JAL;
                            default: begin
                                state_reg   <= S_TRAP;
                                illegal_reg <= 1'b1;
                            end
                        endcase
                    end
                    S_MEMADR: state_reg <= opcode[5] ? S_MEMWRITE : S_MEMREAD;
                    S_EXEC_R, S_EXEC_I, S_JAL: state_reg <= S_ALUWB;
                    S_MEMWB, S_ALUWB, S_BRANCH: state_reg <= S_FETCH;
                    default: state_reg <= S_TRAP;
                endcase
            end
        end
    end

    always_comb begin
        take = 1'b0;
        case (funct3)
            3'b000:  take = zero;
            3'b001:  take = ~zero;
            3'b100:  take = lt;
`ifdef BRANCH_EXT_EN
            3'b101:  take = ~lt;
            3'b110:  take = ltu;
            3'b111:  take = ~ltu;
`endif
            default: take = 1'b0;
        endcase
    end

`ifndef BRANCH_EXT_EN
    logic unused_ltu;
    assign unused_ltu = ltu;
`endif

    always_comb begin
        pc_write_c  = 1'b0;
        mem_write_c = 1'b0;
        mem_req_c   = 1'b0;
        ir_write_c  = 1'b0;
        reg_write_c = 1'b0;
        adr_src     = 1'b0;
        result_src  = 2'b00;
        alu_src_a   = 2'b00;
        alu_src_b   = 2'b00;
        alu_op      = ALUOP_ADD;
        case (state_reg)
            S_FETCH: begin
                mem_req_c  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                ir_write_c = mem_ready;
                pc_write_c = mem_ready;
            end
            S_DECODE: begin
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
            end
            S_MEMREAD: begin
                mem_req_c = 1'b1;
                adr_src   = 1'b1;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_c = 1'b1;
            end
            S_MEMWRITE: begin
                mem_req_c   = 1'b1;
                mem_write_c = 1'b1;
                adr_src     = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = ALUOP_FUNCT;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = ALUOP_FUNCT;
            end
            S_ALUWB: reg_write_c = 1'b1;
            S_JAL: begin
                alu_src_a  = 2'b01;
                alu_src_b  = 2'b10;
                pc_write_c = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a  = 2'b10;
                alu_op     = ALUOP_SUB;
                pc_write_c = take;
            end
            default: ;
        endcase
    end

    // Strobes drop combinationally with reset so an aborted access never completes.
    assign pc_write  = pc_write_c  & ~reset;
    assign mem_write = mem_write_c & ~reset;
    assign mem_req   = mem_req_c   & ~reset;
    assign ir_write  = ir_write_c  & ~reset;
    assign reg_write = reg_write_c & ~reset;

    assign imm_src       = imm_src_of(opcode);
    assign illegal_instr = illegal_reg;
    assign bus_err       = bus_err_reg;

    mc_alu_decoder u_alu_dec (
        .alu_op      (alu_op),
        .funct3      (funct3),
        .funct7b5    (funct7b5),
        .op5         (opcode[5]),
        .alu_control (alu_ctrl3)
    );

    generate
        if (ALU_CTRL_W > 3) begin : g_wide_ctrl
            assign alu_control = {{(ALU_CTRL_W-3){1'b0}}, alu_ctrl3};
        end else begin : g_narrow_ctrl
            assign alu_control = alu_ctrl3[ALU_CTRL_W-1:0];
        end
    endgenerate

endmodule
